// File: rtl/disp_pixbuf.sv
// Pixel FIFO between the VRAM read controller and the display output stage.
// Optional `DISP_PIXBUF_STAT_EN adds BUF_PEAK, the high-water mark of the fill level.
module disp_pixbuf #(
    parameter int DEPTH     = 512,
    parameter int ADDR_W    = 9,
    parameter int BURST_LEN = 16
) (
    input  logic              ACLK,
    input  logic              ARST_N,
    input  logic [31:0]       RDATA,
    input  logic              RVALID,
    input  logic              RREADY,
    output logic              BUF_WREADY,
    input  logic              VRSTART,
    input  logic              DISPON,
    input  logic              DSP_PREP,
    output logic [7:0]        DSP_R,
    output logic [7:0]        DSP_G,
    output logic [7:0]        DSP_B,
    output logic              BUF_UNDER,
    output logic              BUF_OVER,
    input  logic              CLR_ERR
`ifdef DISP_PIXBUF_STAT_EN
    ,
    output logic [ADDR_W:0]   BUF_PEAK
`endif
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] RDY_LVL  = (ADDR_W + 1)'(DEPTH - BURST_LEN);

    logic [23:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [23:0]       pix;

    logic push_req, pop_req, pop, push, under_ev, over_ev;
    logic unused_bits;

    assign unused_bits = ^RDATA[31:24];

    // Handshake: a beat transfers on any cycle with RVALID && RREADY; the controller
    // owns RREADY and only looks at BUF_WREADY to decide whether to issue a burst.
    assign push_req = RVALID && RREADY;
    assign pop_req  = DSP_PREP && DISPON;
    assign pop      = pop_req && (count != '0);
    assign under_ev = pop_req && (count == '0);
    // A full FIFO still accepts a beat when a pop frees a slot in the same cycle.
    assign push     = push_req && !VRSTART && ((count != FULL_LVL) || pop);
    assign over_ev  = push_req && !VRSTART && (count == FULL_LVL) && !pop;

    assign BUF_WREADY = (count <= RDY_LVL);

    assign DSP_R = pix[23:16];
    assign DSP_G = pix[15:8];
    assign DSP_B = pix[7:0];

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= RDATA[23:0];
        end
    end

    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pix    <= '0;
        end else if (VRSTART) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pix    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Read-before-write: when full, a same-cycle push to rd_ptr lands after this read.
            if (pop) begin
                pix <= mem[rd_ptr];
            end else if (!DISPON || under_ev) begin
                pix <= '0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            BUF_UNDER <= 1'b0;
            BUF_OVER  <= 1'b0;
        end else begin
            if (under_ev) begin
                BUF_UNDER <= 1'b1;
            end else if (CLR_ERR) begin
                BUF_UNDER <= 1'b0;
            end
            if (over_ev) begin
                BUF_OVER <= 1'b1;
            end else if (CLR_ERR) begin
                BUF_OVER <= 1'b0;
            end
        end
    end

`ifdef DISP_PIXBUF_STAT_EN
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            BUF_PEAK <= '0;
        end else if (VRSTART || CLR_ERR) begin
            BUF_PEAK <= '0;
        end else if (count > BUF_PEAK) begin
            BUF_PEAK <= count;
        end
    end
`endif

endmodule

// File: tb/tb_disp_pixbuf.sv
// Testbench for disp_pixbuf: vector table for short sequences, queue scoreboard for bulk traffic.
// Builds with or without `DISP_PIXBUF_STAT_EN.
module tb_disp_pixbuf;

    localparam int DEPTH     = 512;
    localparam int ADDR_W    = 9;
    localparam int BURST_LEN = 16;

    logic        ACLK = 1'b0;
    logic        ARST_N;
    logic [31:0] RDATA;
    logic        RVALID, RREADY, VRSTART, DISPON, DSP_PREP, CLR_ERR;
    logic        BUF_WREADY, BUF_UNDER, BUF_OVER;
    logic [7:0]  DSP_R, DSP_G, DSP_B;
`ifdef DISP_PIXBUF_STAT_EN
    logic [ADDR_W:0] BUF_PEAK;
`endif

    disp_pixbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
        .ACLK(ACLK), .ARST_N(ARST_N), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .BUF_WREADY(BUF_WREADY), .VRSTART(VRSTART), .DISPON(DISPON), .DSP_PREP(DSP_PREP),
        .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B), .BUF_UNDER(BUF_UNDER),
        .BUF_OVER(BUF_OVER), .CLR_ERR(CLR_ERR)
`ifdef DISP_PIXBUF_STAT_EN
        , .BUF_PEAK(BUF_PEAK)
`endif
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_pix;
    logic        m_under, m_over;
    int          m_peak;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        prep;
        logic        don;
        logic        clr;
        logic [23:0] e_pix;
        logic        e_under;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: update the reference model, drive inputs, then compare after the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic prep,
                        input logic don, input logic vrs, input logic clr);
        int  sz;
        logic pop_ok, under, over, acc;
        sz     = exp_q.size();
        pop_ok = prep && don && (sz > 0);
        under  = prep && don && (sz == 0);
        over   = 1'b0;
        if (vrs || clr) m_peak = 0;
        else if (sz > m_peak) m_peak = sz;
        if (vrs) begin
            exp_q.delete();
            exp_pix = '0;
        end else begin
            acc  = v && ((sz != DEPTH) || pop_ok);
            over = v && (sz == DEPTH) && !pop_ok;
            if (pop_ok) exp_pix = exp_q.pop_front();
            else if (!don || under) exp_pix = '0;
            if (acc) exp_q.push_back(d[23:0]);
        end
        if (under) m_under = 1'b1;
        else if (clr) m_under = 1'b0;
        if (over) m_over = 1'b1;
        else if (clr) m_over = 1'b0;

        RVALID = v; RREADY = v; RDATA = d; DSP_PREP = prep; DISPON = don;
        VRSTART = vrs; CLR_ERR = clr;
        @(posedge ACLK);
        #1;
        chk("dsp_pix", {8'h0, DSP_R, DSP_G, DSP_B}, {8'h0, exp_pix});
        chk("buf_under", {31'h0, BUF_UNDER}, {31'h0, m_under});
        chk("buf_over", {31'h0, BUF_OVER}, {31'h0, m_over});
        chk("buf_wready", {31'h0, BUF_WREADY},
            {31'h0, ((DEPTH - exp_q.size()) >= BURST_LEN)});
`ifdef DISP_PIXBUF_STAT_EN
        chk("buf_peak", {22'h0, BUF_PEAK}, m_peak);
`endif
        @(negedge ACLK);
        RVALID = 1'b0; RREADY = 1'b0; DSP_PREP = 1'b0; VRSTART = 1'b0; CLR_ERR = 1'b0;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
        tbl[2]  = '{1'b1, 32'h00112233, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
        tbl[3]  = '{1'b1, 32'hFF445566, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 24'h112233, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 24'h445566, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 24'h445566, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 24'h000000, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 24'h000000, 1'b0};
        tbl[9]  = '{1'b1, 32'h00778899, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 24'h778899, 1'b1};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 24'h778899, 1'b0};
        tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};

        ARST_N = 1'b0; RDATA = '0; RVALID = 1'b0; RREADY = 1'b0; VRSTART = 1'b0;
        DISPON = 1'b0; DSP_PREP = 1'b0; CLR_ERR = 1'b0;
        exp_pix = '0; m_under = 1'b0; m_over = 1'b0; m_peak = 0;
        repeat (3) @(negedge ACLK);
        chk("rst_wready", {31'h0, BUF_WREADY}, 32'h1);
        chk("rst_pix", {8'h0, DSP_R, DSP_G, DSP_B}, 32'h0);
        chk("rst_under", {31'h0, BUF_UNDER}, 32'h0);
        chk("rst_over", {31'h0, BUF_OVER}, 32'h0);
        ARST_N = 1'b1;
        @(negedge ACLK);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].prep, tbl[i].don, 1'b0, tbl[i].clr);
            chk($sformatf("tbl%0d_pix", i), {8'h0, DSP_R, DSP_G, DSP_B}, {8'h0, tbl[i].e_pix});
            chk($sformatf("tbl%0d_under", i), {31'h0, BUF_UNDER}, {31'h0, tbl[i].e_under});
        end

        // 16-beat burst then 16 requests; first pixel AA/BB/CC right after the first request.
        for (int i = 0; i < 16; i++) step(1'b1, 32'h00AABBCC + i, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("burst_first_r", {24'h0, DSP_R}, 32'hAA);
        chk("burst_first_g", {24'h0, DSP_G}, 32'hBB);
        chk("burst_first_b", {24'h0, DSP_B}, 32'hCC);
        pop_n(15);
        chk("burst_drained", exp_q.size(), 0);

        // Threshold around DEPTH-BURST_LEN, then overflow and full-level push+pop.
        push_n(DEPTH - BURST_LEN);
        chk("wready_at_496", {31'h0, BUF_WREADY}, 32'h1);
        push_n(1);
        chk("wready_at_497", {31'h0, BUF_WREADY}, 32'h0);
        pop_n(1);
        chk("wready_pop_496", {31'h0, BUF_WREADY}, 32'h1);
        push_n(BURST_LEN);
        step(1'b1, 32'h00DEAD00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("over_on_513", {31'h0, BUF_OVER}, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("over_cleared", {31'h0, BUF_OVER}, 32'h0);
        step(1'b1, 32'h00BEEF00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_push_pop_no_over", {31'h0, BUF_OVER}, 32'h0);
        pop_n(DEPTH);

        // Underflow, then flush at level 100 with a colliding push.
        pop_n(1);
        chk("under_set", {31'h0, BUF_UNDER}, 32'h1);
        push_n(100);
        step(1'b1, 32'h00123456, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("vrs_over", {31'h0, BUF_OVER}, 32'h0);
        chk("vrs_under_kept", {31'h0, BUF_UNDER}, 32'h1);
        chk("vrs_wready", {31'h0, BUF_WREADY}, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        pop_n(1);
        chk("vrs_emptied", {31'h0, BUF_UNDER}, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Constant level 8 through a pointer wrap.
        push_n(8);
        for (int i = 0; i < 600; i++) step(1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
        pop_n(8);
        chk("wrap_drained", exp_q.size(), 0);
`ifdef DISP_PIXBUF_STAT_EN
        chk("peak_is_8", {22'h0, BUF_PEAK}, 32'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_pixbuf.md
Name: disp_pixbuf

Overview:
- Single-clock pixel FIFO directly downstream of the VRAM read controller.
- Captures AXI read-data beats (one XRGB 8:8:8:8 pixel per 32-bit beat) and drives BUF_WREADY back to the controller for burst flow control.
- Delivers one RGB pixel per cycle to the display timing/output stage on demand.
- Flushed at every frame start.

Parameters:
- DEPTH, 512: FIFO depth in pixels; power of two, >= 2*BURST_LEN.
- ADDR_W, 9: log2(DEPTH).
- BURST_LEN, 16: beats per read burst; the free-space threshold for BUF_WREADY.

Ports:
- ACLK  in  1  system clock.
- ARST_N  in  1  asynchronous active-low reset.
- RDATA  in  32  AXI read data; [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored.
- RVALID  in  1  AXI read data valid.
- RREADY  in  1  RREADY as driven by the VRAM controller; a beat is written when RVALID&&RREADY.
- BUF_WREADY  out  1  free space >= BURST_LEN.
- VRSTART  in  1  frame-start pulse; synchronous flush.
- DISPON  in  1  display enable.
- DSP_PREP  in  1  pixel request from the timing stage; one pop per asserted cycle.
- DSP_R / DSP_G / DSP_B  out  8 each  registered pixel output.
- BUF_UNDER  out  1  sticky underflow flag.
- BUF_OVER  out  1  sticky overflow flag.
- CLR_ERR  in  1  synchronous clear of BUF_UNDER and BUF_OVER.

Behaviour:
- Reset (ARST_N=0, asynchronous): wr_ptr=rd_ptr=0, count=0, DSP_R/G/B=0, BUF_UNDER=0, BUF_OVER=0, BUF_WREADY=1.
- Storage: DEPTH x 24-bit RAM. count is an ADDR_W+1-bit register. Pointers wrap DEPTH-1 -> 0 (natural ADDR_W-bit rollover).
- Write: push when RVALID&&RREADY and count<DEPTH.
  - Push while count==DEPTH: the beat is dropped, BUF_OVER<=1, count and pointers unchanged.
- BUF_WREADY = (DEPTH-count) >= BURST_LEN.
  - Decoded from the count register only; no combinational path from any input.
- Read: pop when DSP_PREP && DISPON && count>0.
  - Popped pixel appears on DSP_R/G/B on the next rising edge (1-cycle latency) and holds until the next pop or blank.
- Underflow: DSP_PREP && DISPON && count==0 -> DSP_R/G/B<=0 next cycle, BUF_UNDER<=1, nothing popped.
- DISPON=0: no pops, DSP_R/G/B<=0 every cycle, no underflow flagged; writes continue normally.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - At count==0, a simultaneous push does not satisfy the pop; the pop underflows. No write-to-read bypass.
  - At count==DEPTH, a simultaneous push and pop is legal (the pop frees space): the push is accepted, BUF_OVER stays 0.
- VRSTART=1: next edge sets wr_ptr=rd_ptr=count=0 and DSP_R/G/B=0.
  - Overrides any same-cycle push or pop; that beat is discarded without setting BUF_OVER.
  - Flags are not affected by VRSTART.
- CLR_ERR: flags <=0 next edge. A same-cycle new error event wins, so the flag stays 1.
- RAM read is synchronous, one port per side; no other pipeline stages.

Optional Feature:
DISP_PIXBUF_STAT_EN
- Defined: adds output BUF_PEAK [ADDR_W:0], holding the maximum count seen since the last reset/VRSTART/CLR_ERR.
  - Updated each cycle as max(BUF_PEAK, count).
  - Cleared to 0 on reset, VRSTART or CLR_ERR.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset release, no traffic -> BUF_WREADY=1, DSP_R/G/B=0, flags 0, no pops on DSP_PREP with DISPON=0.
- Write 16 beats RDATA=0x00AABBCC..., then DISPON=1 and DSP_PREP for 16 cycles -> DSP_R=0xAA, G=0xBB, B=0xCC on the cycle after the first request; order preserved; count returns to 0.
- Fill to DEPTH-BURST_LEN=496 -> BUF_WREADY=1. Push one more (497) -> BUF_WREADY=0. Pop one -> BUF_WREADY=1.
- Fill to 512 and push a 513th beat -> beat dropped, BUF_OVER=1. CLR_ERR pulse -> BUF_OVER=0.
- Empty FIFO, DISPON=1, DSP_PREP=1 -> DSP_R/G/B=0, BUF_UNDER=1. Pulse VRSTART at count=100 with a same-cycle push -> count=0, no BUF_OVER, BUF_UNDER still 1.
- Drive wr_ptr through the wrap by 600 push/pop cycles at constant level 8 -> data intact across the 511->0 transition. With DISP_PIXBUF_STAT_EN, BUF_PEAK=8.
